inst_rom_arbiter: RTL and testbench

- Shares the single combinational instruction ROM port between two requesters: the IF-stage fetch (primary) and a debug/program-inspection read port (secondary).
- Arbitrates every cycle and drives the ROM chip-enable and address.
- Registers the returned instruction word with a valid strobe, giving a 1-cycle read latency.
- Raises a stall request to the pipeline controller whenever a fetch is denied, and guarantees forward progress for the debug port with a starvation counter.

---
 rtl/inst_rom_arbiter.sv | 50 +++++
 tb/tb_inst_rom_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares one instruction ROM port between IF fetch and a debug reader, with starvation-bounded debug priority.
module inst_rom_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_stallreq,
  output logic [31:0] if_inst,
  output logic        if_valid,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_valid,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);
  logic [WAIT_W-1:0] wait_cnt;
  logic force_dbg, gnt_if, gnt_dbg;
  always_comb begin
    force_dbg   = wait_cnt == WAIT_W'(MAX_WAIT);
    gnt_dbg     = dbg_req && (!if_req || force_dbg);
    gnt_if      = if_req && !gnt_dbg;
    rom_ce      = gnt_if | gnt_dbg;
    rom_addr    = gnt_if ? if_addr : gnt_dbg ? dbg_addr : '0;
    dbg_gnt     = gnt_dbg;
    if_stallreq = if_req & ~gnt_if;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_inst   <= '0;
      if_valid  <= 1'b0;
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if_valid  <= gnt_if && !if_flush;
      dbg_valid <= gnt_dbg;
      if (gnt_if && !if_flush) if_inst <= rom_inst;
      if (gnt_dbg) dbg_rdata <= rom_inst;
      // saturates so a forced grant stays asserted until taken
      wait_cnt  <= (!dbg_req || gnt_dbg) ? '0 : force_dbg ? wait_cnt : wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter: directed checks of arbitration, latency, flush, starvation and async reset.
module tb_inst_rom_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, if_flush = 1'b0, dbg_req = 1'b0;
  logic [31:0] if_addr = '0, dbg_addr = '0;
  logic if_stallreq, if_valid, dbg_gnt, dbg_valid, rom_ce;
  logic [31:0] if_inst, dbg_rdata, rom_addr, rom_inst;
  logic [31:0] mem [16];
  int checks = 0, passes = 0;

  always #5 clk = ~clk;
  assign rom_inst = rom_ce ? mem[rom_addr[5:2]] : 32'h0;

  inst_rom_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_stallreq(if_stallreq), .if_inst(if_inst), .if_valid(if_valid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_valid(dbg_valid), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  task automatic test_reset();
    #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid got %b want 0", if_valid); else passes++;
    checks++; if (dbg_valid !== 1'b0) $display("FAIL rst_dbg_valid got %b want 0", dbg_valid); else passes++;
    checks++; if (if_inst !== 32'h0) $display("FAIL rst_if_inst got %h want 0", if_inst); else passes++;
    checks++; if (dbg_rdata !== 32'h0) $display("FAIL rst_dbg_rdata got %h want 0", dbg_rdata); else passes++;
    checks++; if (rom_ce !== 1'b0) $display("FAIL rst_rom_ce got %b want 0", rom_ce); else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    logic [31:0] exp [3];
    exp[0] = 32'h34011100; exp[1] = 32'h34020020; exp[2] = 32'h3403ff00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if_req = 1'b1; if_addr = 32'(4 * i); #1;
      checks++; if (if_stallreq !== 1'b0) $display("FAIL fetch_stall[%0d] got %b want 0", i, if_stallreq); else passes++;
      checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'(4 * i)) $display("FAIL fetch_rom[%0d] got ce=%b addr=%h want ce=1 addr=%h", i, rom_ce, rom_addr, 4 * i); else passes++;
      @(posedge clk); #1;
      checks++; if (if_valid !== 1'b1 || if_inst !== exp[i]) $display("FAIL fetch_resp[%0d] got v=%b inst=%h want v=1 inst=%h", i, if_valid, if_inst, exp[i]); else passes++;
    end
    @(negedge clk); if_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL fetch_idle_valid got %b want 0", if_valid); else passes++;
  endtask

  task automatic test_debug_only();
    @(negedge clk); dbg_req = 1'b1; dbg_addr = 32'h10; #1;
    checks++; if (dbg_gnt !== 1'b1 || rom_addr !== 32'h10) $display("FAIL dbg_gnt got gnt=%b addr=%h want gnt=1 addr=00000010", dbg_gnt, rom_addr); else passes++;
    @(posedge clk); #1;
    checks++; if (dbg_valid !== 1'b1 || dbg_rdata !== 32'h0) $display("FAIL dbg_resp got v=%b d=%h want v=1 d=0", dbg_valid, dbg_rdata); else passes++;
    checks++; if (if_valid !== 1'b0) $display("FAIL dbg_if_valid got %b want 0", if_valid); else passes++;
    @(negedge clk); dbg_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_valid !== 1'b0) $display("FAIL dbg_strobe got %b want 0", dbg_valid); else passes++;
  endtask

  task automatic test_contention();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0; dbg_addr = 32'h14; dbg_req = (c <= 4);
      #1;
      checks++; if (dbg_gnt !== (c == 4)) $display("FAIL cont_gnt[%0d] got %b want %b", c, dbg_gnt, c == 4); else passes++;
      checks++; if (if_stallreq !== (c == 4)) $display("FAIL cont_stall[%0d] got %b want %b", c, if_stallreq, c == 4); else passes++;
      checks++; if (rom_addr !== ((c == 4) ? 32'h14 : 32'h0)) $display("FAIL cont_addr[%0d] got %h want %h", c, rom_addr, (c == 4) ? 32'h14 : 32'h0); else passes++;
      @(posedge clk); #1;
      checks++; if (dbg_valid !== (c == 4) || if_valid !== (c != 4)) $display("FAIL cont_valid[%0d] got dv=%b iv=%b want dv=%b iv=%b", c, dbg_valid, if_valid, c == 4, c != 4); else passes++;
    end
    checks++; if (dbg_rdata !== 32'hdeadbeef) $display("FAIL cont_rdata got %h want deadbeef", dbg_rdata); else passes++;
  endtask

  task automatic test_flush();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h20; if_flush = 1'b1; #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h20) $display("FAIL flush_rom got ce=%b addr=%h want ce=1 addr=00000020", rom_ce, rom_addr); else passes++;
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h34011100) $display("FAIL flush_resp got v=%b inst=%h want v=0 inst=34011100", if_valid, if_inst); else passes++;
    @(negedge clk); if_addr = 32'h24; if_flush = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h00221820) $display("FAIL flush_next got v=%b inst=%h want v=1 inst=00221820", if_valid, if_inst); else passes++;
    @(negedge clk); if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h00221820) $display("FAIL flush_idle got v=%b inst=%h want v=0 inst=00221820", if_valid, if_inst); else passes++;
    @(negedge clk); if_flush = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); if_req = 1'b1; if_addr = 32'h8; dbg_req = 1'b1; dbg_addr = 32'h14;
      @(posedge clk);
    end
    #2; rst = 1'b1; #1;
    checks++; if (if_valid !== 1'b0 || dbg_valid !== 1'b0) $display("FAIL arst_valid got iv=%b dv=%b want 0 0", if_valid, dbg_valid); else passes++;
    checks++; if (if_inst !== 32'h0 || dbg_rdata !== 32'h0) $display("FAIL arst_data got inst=%h rdata=%h want 0 0", if_inst, dbg_rdata); else passes++;
    @(negedge clk); rst = 1'b0; if_addr = 32'h4;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (dbg_gnt !== (c == 4)) $display("FAIL arst_gnt[%0d] got %b want %b", c, dbg_gnt, c == 4); else passes++;
      @(posedge clk); #1;
      if (c == 0) begin
        checks++; if (if_valid !== 1'b1 || if_inst !== 32'h34020020) $display("FAIL arst_fetch got v=%b inst=%h want v=1 inst=34020020", if_valid, if_inst); else passes++;
      end
    end
    @(negedge clk); dbg_req = 1'b0;
  endtask

  task automatic test_withdraw();
    logic pat [8];
    for (int c = 0; c < 8; c++) pat[c] = (c != 2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); if_req = 1'b1; if_addr = 32'h0; dbg_req = pat[c]; #1;
      checks++; if (dbg_gnt !== (c == 7)) $display("FAIL wd_gnt[%0d] got %b want %b", c, dbg_gnt, c == 7); else passes++;
      @(posedge clk);
    end
    @(negedge clk); dbg_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_valid !== 1'b0 || if_valid !== 1'b0) $display("FAIL wd_idle got dv=%b iv=%b want 0 0", dbg_valid, if_valid); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h11110000 + 32'(i);
    mem[0] = 32'h34011100; mem[1] = 32'h34020020; mem[2] = 32'h3403ff00;
    mem[4] = 32'h0; mem[5] = 32'hdeadbeef; mem[8] = 32'h8c010008; mem[9] = 32'h00221820;
    test_reset();
    test_fetch_only();
    test_debug_only();
    test_contention();
    test_flush();
    test_async_reset();
    test_withdraw();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
